proc_run_ctrl: RTL and testbench
================================

# proc_run_ctrl

Run controller that sits directly upstream of `processor_1` and drives its `init`/`restart` inputs. It consumes the processor's `done` output, measures execution length in clock cycles, and enforces a timeout. It replaces hand-written testbench init/stop sequencing with a start/ack handshake, so a host FSM or a bench can launch programs back-to-back.

## Interface
- `INIT_CYCLES`, default 2: cycles `proc_init` is held high on a cold start; legal range ≥1.
- `CNT_W`, default 16: width of the cycle counter.
- `TIMEOUT`, default 50000: maximum RUN cycles before forced stop; must satisfy 1 ≤ TIMEOUT ≤ 2^CNT_W−1.

Ports:
- `clock` input 1: single clock, rising edge.
- `init_n` input 1: reset, asynchronous assert, active-low.
- `start` input 1: launch request; sampled only in IDLE.
- `warm` input 1: qualifies `start`. 0 = cold start (init pulse); 1 = warm start (restart pulse).
- `ack` input 1: host consumes the result; sampled only in DONE.
- `proc_done` input 1: the processor's `done`.
- `proc_init` output 1: drives processor `init`.
- `proc_restart` output 1: drives processor `restart`.
- `busy` output 1: high in INIT, RESTART and RUN.
- `result_valid` output 1: high in DONE.
- `timed_out` output 1: high in DONE when the run ended by timeout; 0 otherwise.
- `cycle_count` output CNT_W: RUN cycles elapsed; frozen in DONE.

## Operation
- All outputs are registered.
- States: IDLE, INIT, RESTART, RUN, DONE.

Reset (`init_n`=0, asynchronous, any state):
- State goes to IDLE.
- `proc_init`=1, `proc_restart`=0, `busy`=0, `result_valid`=0, `timed_out`=0, `cycle_count`=0.

IDLE:
- Processor is parked: `proc_init`=1, `proc_restart`=0.
- `start`=1 with `warm`=0 → INIT.
- `start`=1 with `warm`=1 → RESTART.
- `start`=0 → stay in IDLE.

INIT:
- `proc_init`=1 for exactly INIT_CYCLES cycles, using an internal counter.
- Then → RUN.
- `proc_done` is ignored.

RESTART:
- `proc_init`=0, `proc_restart`=1 for exactly 1 cycle.
- Then → RUN.
- `proc_done` is ignored.

RUN:
- `proc_init`=0, `proc_restart`=0.
- On entry, `cycle_count` clears to 0.
- Each cycle with `proc_done`=0 and `cycle_count` < TIMEOUT: `cycle_count` increments by 1.
- `proc_done`=1 → DONE with `timed_out`=0; `cycle_count` is not incremented that cycle.
- `proc_done`=0 and `cycle_count`==TIMEOUT → DONE with `timed_out`=1.
- If `proc_done`=1 and the timeout condition hold in the same cycle, `proc_done` wins (`timed_out`=0).
- The counter never wraps: the TIMEOUT bound guarantees it.

DONE:
- `result_valid`=1.
- `proc_init`=1, re-parking the processor.
- `cycle_count` and `timed_out` hold.
- `ack`=1 → IDLE. `result_valid` and `timed_out` clear; `cycle_count` holds its last value until the next RUN entry.
- `start` is ignored in DONE, including when asserted in the same cycle as `ack`. The host must re-assert `start` in IDLE.

Other rules:
- `ack` outside DONE and `start` outside IDLE have no effect.
- `warm` is sampled only together with `start` in IDLE.

## Timing
- Cold start, `start` sampled at edge T:
  - T+1: INIT, `busy`=1, `proc_init`=1.
  - T+1+INIT_CYCLES: RUN, `proc_init`=0.
- Warm start, `start` sampled at edge T:
  - T+1: RESTART, `proc_restart`=1.
  - T+2: RUN.
- Done latency: `proc_done` sampled high at edge D → from D+1, `result_valid`=1, `busy`=0, `proc_init`=1.
- Count meaning: `cycle_count` equals the number of RUN edges on which `proc_done` was sampled low. A `proc_done` seen on the first RUN edge gives 0.
- Timeout latency: DONE is entered on the edge after the one where `cycle_count` reaches TIMEOUT. Total time in RUN is TIMEOUT+1 cycles.
- Reset mid-operation: outputs take their reset values immediately, asynchronously. Operation resumes on the first clock edge after `init_n` deasserts.

## Test plan
- Cold start, INIT_CYCLES=2, `proc_done` raised 10 cycles after RUN entry:
  - `proc_init` high for 2 cycles, then low.
  - `result_valid`=1, `cycle_count`=10, `timed_out`=0.
- Warm start (`warm`=1):
  - `proc_restart` is a single-cycle pulse with `proc_init`=0.
  - With `proc_done` on the first RUN edge, `cycle_count`=0.
- TIMEOUT=20, `proc_done` held low:
  - DONE after 21 RUN cycles, `timed_out`=1, `cycle_count`=20.
  - Repeat with `proc_done`=1 on the timeout edge: `timed_out`=0.
- `start`+`ack` asserted together in DONE:
  - Returns to IDLE, no new run begins.
  - A following `start` in IDLE launches normally.
- `init_n` pulsed low mid-RUN:
  - Outputs go to reset values without waiting for a clock edge; state is IDLE.
  - `proc_done` pulses during INIT or RESTART never produce DONE.

Source files
------------

// File: rtl/proc_run_ctrl_if.sv
// proc_run_ctrl_if: host/processor-facing handshake bundle of the run controller.
interface proc_run_ctrl_if #(parameter int CNT_W = 16);
  logic start;
  logic warm;
  logic ack;
  logic proc_done;
  logic proc_init;
  logic proc_restart;
  logic busy;
  logic result_valid;
  logic timed_out;
  logic [CNT_W-1:0] cycle_count;
  modport master (
    output start, warm, ack, proc_done,
    input  proc_init, proc_restart, busy, result_valid, timed_out, cycle_count
  );
  modport slave (
    input  start, warm, ack, proc_done,
    output proc_init, proc_restart, busy, result_valid, timed_out, cycle_count
  );
endinterface

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: launches processor runs (cold/warm), measures length, enforces a timeout.
module proc_run_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 50000
) (
  input  logic                  clock,
  input  logic                  init_n,
  proc_run_ctrl_if.slave        bus
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INIT, RESTART, RUN, DONE} state_t;
  state_t        st;
  logic [IW-1:0] icnt;
  always_ff @(posedge clock or negedge init_n) begin
    if (!init_n) begin
      st                <= IDLE;
      icnt              <= '0;
      bus.proc_init     <= 1'b1;
      bus.proc_restart  <= 1'b0;
      bus.busy          <= 1'b0;
      bus.result_valid  <= 1'b0;
      bus.timed_out     <= 1'b0;
      bus.cycle_count   <= '0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          bus.busy <= 1'b1;
          if (bus.warm) begin
            st               <= RESTART;
            bus.proc_init    <= 1'b0;
            bus.proc_restart <= 1'b1;
          end else begin
            st   <= INIT;
            icnt <= IW'(1);
          end
        end
        INIT: if (icnt == IW'(INIT_CYCLES)) begin
          st              <= RUN;
          bus.proc_init   <= 1'b0;
          bus.cycle_count <= '0;
        end else begin
          icnt <= icnt + IW'(1);
        end
        RESTART: begin
          st               <= RUN;
          bus.proc_restart <= 1'b0;
          bus.cycle_count  <= '0;
        end
        RUN: if (bus.proc_done || bus.cycle_count == CNT_W'(TIMEOUT)) begin
          // a done seen on the timeout edge still counts as a normal finish
          st               <= DONE;
          bus.busy         <= 1'b0;
          bus.result_valid <= 1'b1;
          bus.proc_init    <= 1'b1;
          bus.timed_out    <= !bus.proc_done;
        end else begin
          bus.cycle_count <= bus.cycle_count + CNT_W'(1);
        end
        DONE: if (bus.ack) begin
          st               <= IDLE;
          bus.result_valid <= 1'b0;
          bus.timed_out    <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: randomized launches checked against a per-run transaction model.
module tb_proc_run_ctrl;
  localparam int INIT_CYCLES = 2;
  localparam int CNT_W       = 16;
  localparam int TIMEOUT     = 20;
  logic clock = 1'b0;
  logic init_n;
  int checks = 0;
  int errors = 0;
  proc_run_ctrl_if #(.CNT_W(CNT_W)) bus();
  proc_run_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .init_n(init_n),
    .bus   (bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pins"}, {bus.proc_init, bus.proc_restart, bus.busy}, 3'b100);
    chk({tag, "_res"}, {bus.result_valid, bus.timed_out}, 2'b00);
    chk({tag, "_cnt"}, bus.cycle_count, 0);
  endtask
  // done first seen high on 0-based RUN edge k; k beyond TIMEOUT means never
  task automatic run_txn(input bit w, input int k);
    int ex;
    logic [CNT_W-1:0] exp_cnt;
    logic exp_to;
    ex      = (k <= TIMEOUT) ? k : TIMEOUT;
    exp_cnt = CNT_W'(ex);
    exp_to  = (k > TIMEOUT);
    @(negedge clock);
    chk("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.warm  = w;
    @(negedge clock);
    bus.start = 1'b0;
    bus.warm  = 1'($urandom);
    if (!w) begin
      for (int i = 0; i < INIT_CYCLES; i++) begin
        chk("init_pins", {bus.proc_init, bus.proc_restart, bus.busy}, 3'b101);
        bus.proc_done = 1'($urandom);
        bus.ack       = 1'($urandom);
        @(negedge clock);
      end
    end else begin
      chk("restart_pins", {bus.proc_init, bus.proc_restart, bus.busy}, 3'b011);
      bus.proc_done = 1'($urandom);
      bus.ack       = 1'($urandom);
      @(negedge clock);
    end
    for (int e = 0; e <= ex; e++) begin
      chk("run_pins", {bus.proc_init, bus.proc_restart, bus.busy, bus.result_valid}, 4'b0010);
      chk("run_cnt", bus.cycle_count, e);
      bus.proc_done = (e == k);
      bus.ack       = 1'($urandom);
      @(negedge clock);
    end
    bus.proc_done = 1'b0;
    bus.ack       = 1'b0;
    chk("done_pins", {bus.proc_init, bus.proc_restart, bus.busy, bus.result_valid}, 4'b1001);
    chk("done_to", bus.timed_out, exp_to);
    chk("done_cnt", bus.cycle_count, exp_cnt);
    repeat ($urandom_range(0, 3)) begin
      bus.start     = 1'($urandom);
      bus.proc_done = 1'($urandom);
      @(negedge clock);
      chk("hold_rv", {bus.result_valid, bus.busy, bus.timed_out}, {2'b10, exp_to});
      chk("hold_cnt", bus.cycle_count, exp_cnt);
    end
    bus.ack       = 1'b1;
    bus.start     = 1'($urandom);
    bus.proc_done = 1'b0;
    @(negedge clock);
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    chk("ack_idle", {bus.proc_init, bus.proc_restart, bus.busy, bus.result_valid, bus.timed_out}, 5'b10000);
    chk("ack_cnt", bus.cycle_count, exp_cnt);
    @(negedge clock);
    chk("no_relaunch", {bus.proc_init, bus.proc_restart, bus.busy}, 3'b100);
  endtask
  initial begin
    init_n        = 1'b0;
    bus.start     = 1'b0;
    bus.warm      = 1'b0;
    bus.ack       = 1'b0;
    bus.proc_done = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    init_n = 1'b1;
    @(negedge clock);
    chk_reset_vals("idle");
    run_txn(1'b0, 10);
    run_txn(1'b1, 0);
    run_txn(1'b0, 25);
    run_txn(1'b1, TIMEOUT);
    run_txn(1'b0, TIMEOUT - 1);
    run_txn(1'b1, TIMEOUT + 1);
    repeat (12) run_txn(1'($urandom), int'($urandom_range(0, 30)));
    @(negedge clock);
    bus.start = 1'b1;
    bus.warm  = 1'b0;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (INIT_CYCLES + 4) @(negedge clock);
    chk("pre_rst_busy", {bus.busy, bus.proc_init}, 2'b10);
    #2 init_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clock);
    init_n = 1'b1;
    @(negedge clock);
    chk_reset_vals("post_rst");
    run_txn(1'b1, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
